// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier operand issue stage.
package mult_pkg;

    localparam int N_DEF   = 4;
    localparam int M_DEF   = 4;
    localparam int ENTRY_W = N_DEF + M_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mult_issue_fifo.sv
// Synchronous DEPTH x W operand FIFO.
// Pointers carry a wrap bit so that full and empty can be told apart.
module mult_issue_fifo
    import mult_pkg::*;
#(
    parameter int W     = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mult_issue.sv
// Operand issue stage feeding the shift-add multiplier.
// Optional launch counter port issue_cnt when MULT_ISSUE_STATS_EN is defined.
module mult_issue
    import mult_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [M-1:0] in_b,
    output logic         data_rdy,
    output logic [N-1:0] mult1,
    output logic [M-1:0] mult2,
    input  logic         result_rdy,
    output logic         busy,
    output logic         err
`ifdef MULT_ISSUE_STATS_EN
    ,
    output logic [15:0]  issue_cnt
`endif
);

    localparam int W = N + M;

    logic         full, empty;
    logic         push, pop;
    logic [W-1:0] head;

    state_e       state_q;
    logic         data_rdy_q;
    logic [N-1:0] mult1_q;
    logic [M-1:0] mult2_q;
    logic         err_q;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    // In BUSY a pop is only allowed on the completion of the op in flight.
    assign pop      = !empty && ((state_q == IDLE) || result_rdy);

    mult_issue_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_a, in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_rdy_q <= 1'b0;
            mult1_q    <= '0;
            mult2_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            data_rdy_q <= pop;
            if (pop) begin
                mult1_q <= head[W-1:M];
                mult2_q <= head[M-1:0];
            end
            unique case (state_q)
                IDLE: begin
                    if (result_rdy) err_q   <= 1'b1;
                    if (!empty)     state_q <= BUSY;
                end
                BUSY: begin
                    if (result_rdy && empty) state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_rdy = data_rdy_q;
    assign mult1    = mult1_q;
    assign mult2    = mult2_q;
    assign busy     = (state_q == BUSY);
    assign err      = err_q;

`ifdef MULT_ISSUE_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)      cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 16'd1;
    end

    assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mult_issue.sv
// Scoreboard bench for mult_issue with a behavioural M+1 latency multiplier.
module tb_mult_issue;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } op_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic       data_rdy;
    logic [3:0] mult1, mult2;
    logic       result_rdy;
    logic       busy, err;
`ifdef MULT_ISSUE_STATS_EN
    logic [15:0] issue_cnt;
`endif

    logic       model_en, res_man, res_model;
    logic [7:0] mprod;
    int         mcnt;
    int         cyc;

    op_t        exp_q[$];
    logic [7:0] prod_q[$];
    int         launch_t[$];
    int         launches, results;
    int         checks, errors;

    always #5 clk = ~clk;

    assign result_rdy = model_en ? res_model : res_man;

    mult_issue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .data_rdy   (data_rdy),
        .mult1      (mult1),
        .mult2      (mult2),
        .result_rdy (result_rdy),
        .busy       (busy),
        .err        (err)
`ifdef MULT_ISSUE_STATS_EN
        ,
        .issue_cnt  (issue_cnt)
`endif
    );

    // Multiplier model: result_rdy pulses M+1 cycles after data_rdy.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        res_model <= 1'b0;
        if (rst) begin
            mcnt <= 0;
        end else if (data_rdy) begin
            mcnt  <= M;
            mprod <= {4'b0, mult1} * {4'b0, mult2};
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) res_model <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        op_t e;
        if (!rst && data_rdy) begin
            launches++;
            launch_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL launch_unexp: got %0d/%0d expected none",
                         mult1, mult2);
            end else begin
                e = exp_q.pop_front();
                chk("launch_a", {28'b0, mult1}, {28'b0, e.a});
                chk("launch_b", {28'b0, mult2}, {28'b0, e.b});
                prod_q.push_back(e.p);
            end
        end
        if (model_en && res_model) begin
            results++;
            if (prod_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexp: got %0d expected none", mprod);
            end else begin
                chk("product", {24'b0, mprod}, {24'b0, prod_q.pop_front()});
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] p, output logic acc,
                        output int t);
        op_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        acc = in_ready;
        t   = cyc;
        if (acc) begin
            e.a = a;
            e.b = b;
            e.p = p;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_launch(input int target, input int budget,
                               input string nm);
        for (int i = 0; i < budget && launches < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, {31'b0, launches >= target}, 32'd1);
    endtask

    task automatic wait_done(input int nres, input string nm);
        for (int i = 0; i < 80 && (busy || results < nres); i++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, {31'b0, !busy && results >= nres}, 32'd1);
    endtask

    task automatic pulse_res();
        res_man = 1'b1;
        @(posedge clk);
        #1;
        res_man = 1'b0;
    endtask

    initial begin
        logic acc;
        int   t, base, lb;
        cyc = 0;
        checks = 0;
        errors = 0;
        launches = 0;
        results = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        model_en = 1'b1;
        res_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_data_rdy", {31'b0, data_rdy}, 32'd0);
        chk("rst_mult1", {28'b0, mult1}, 32'd0);
        chk("rst_mult2", {28'b0, mult2}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
`ifdef MULT_ISSUE_STATS_EN
        chk("rst_issue_cnt", {16'b0, issue_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single op
        push(4'd3, 4'd5, 8'd15, acc, t);
        wait_launch(1, 20, "single_launch");
        chk("single_latency", launch_t[0] - t, 32'd2);
        wait_done(1, "single_done");

        // Burst of four
        base = launches;
        push(4'd2, 4'd7, 8'd14, acc, t);
        push(4'd15, 4'd15, 8'd225, acc, t);
        push(4'd0, 4'd9, 8'd0, acc, t);
        push(4'd1, 4'd1, 8'd1, acc, t);
        wait_launch(base + 4, 80, "burst_launch");
        for (int i = 1; i < 4 && base + i < launch_t.size(); i++)
            chk("burst_gap", launch_t[base+i] - launch_t[base+i-1], M + 2);
        wait_done(5, "burst_done");

        // Backpressure: completion withheld
        model_en = 1'b0;
        base = launches;
        push(4'd1, 4'd2, 8'd2, acc, t);
        chk("bp_acc1", {31'b0, acc}, 32'd1);
        push(4'd2, 4'd3, 8'd6, acc, t);
        push(4'd3, 4'd4, 8'd12, acc, t);
        push(4'd4, 4'd5, 8'd20, acc, t);
        push(4'd5, 4'd6, 8'd30, acc, t);
        chk("bp_acc5", {31'b0, acc}, 32'd1);
        push(4'd6, 4'd7, 8'd42, acc, t);
        chk("bp_full_reject", {31'b0, acc}, 32'd0);
        chk("bp_in_ready_lo", {31'b0, in_ready}, 32'd0);
        pulse_res();
        @(negedge clk);
        chk("bp_in_ready_hi", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            idle(2);
            pulse_res();
        end
        idle(2);
        chk("bp_idle", {31'b0, busy}, 32'd0);
        chk("bp_launches", launches - base, 32'd5);
        chk("bp_drained", exp_q.size(), 32'd0);
        idle(8);
        prod_q.delete();

        // Stray completion while IDLE
        lb = launches;
        pulse_res();
        @(negedge clk);
        chk("stray_err", {31'b0, err}, 32'd1);
        chk("stray_no_launch", {31'b0, data_rdy}, 32'd0);
        @(posedge clk);
        #1;
        idle(3);
        chk("stray_err_sticky", {31'b0, err}, 32'd1);
        chk("stray_busy", {31'b0, busy}, 32'd0);
        chk("stray_launches", launches, lb);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("stray_err_clr", {31'b0, err}, 32'd0);
        model_en = 1'b1;
        results = 0;

        // Reset two cycles after a launch with two entries queued
        lb = launches;
        push(4'd9, 4'd9, 8'd81, acc, t);
        push(4'd10, 4'd3, 8'd30, acc, t);
        push(4'd4, 4'd4, 8'd16, acc, t);
        chk("rmo_launch", launches - lb, 32'd1);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        prod_q.delete();
        @(negedge clk);
        chk("rmo_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rmo_data_rdy", {31'b0, data_rdy}, 32'd0);
        chk("rmo_mult1", {28'b0, mult1}, 32'd0);
        chk("rmo_mult2", {28'b0, mult2}, 32'd0);
        chk("rmo_busy", {31'b0, busy}, 32'd0);
        chk("rmo_err", {31'b0, err}, 32'd0);
`ifdef MULT_ISSUE_STATS_EN
        chk("rmo_issue_cnt", {16'b0, issue_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        lb = launches;
        idle(4);
        chk("rmo_fifo_empty", launches, lb);

        // Fresh traffic after reset: five launches total
        push(4'd6, 4'd7, 8'd42, acc, t);
        wait_launch(lb + 1, 20, "post_rst_launch");
        chk("post_rst_latency", launch_t[launch_t.size()-1] - t, 32'd2);
        push(4'd2, 4'd2, 8'd4, acc, t);
        push(4'd3, 4'd3, 8'd9, acc, t);
        push(4'd7, 4'd7, 8'd49, acc, t);
        push(4'd15, 4'd1, 8'd15, acc, t);
        wait_launch(lb + 5, 80, "post_rst_burst");
        wait_done(5, "post_rst_done");
`ifdef MULT_ISSUE_STATS_EN
        chk("issue_cnt", {16'b0, issue_cnt}, 32'd5);
`endif
        chk("final_exp_q", exp_q.size(), 32'd0);
        chk("final_prod_q", prod_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
